// File: rtl/match_ctrl_if.sv
// Match controller bus: frame/point/start inputs and score/phase outputs.
interface match_ctrl_if;
    logic       vblnk_in;
    logic       point_p1;
    logic       point_p2;
    logic       start_btn;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_active;
    logic       serve;
    logic       show_winner;
    logic       player_won;

    modport master (
        output vblnk_in, point_p1, point_p2, start_btn,
        input  score_p1, score_p2, game_active, serve, show_winner, player_won
    );
    modport slave (
        input  vblnk_in, point_p1, point_p2, start_btn,
        output score_p1, score_p2, game_active, serve, show_winner, player_won
    );
endinterface

// File: rtl/match_ctrl.sv
// Match sequencer: scores points, pauses between serves, holds the winner screen.
// All timing is in frames counted on vblnk rising edges.
module match_ctrl #(
    parameter int WIN_SCORE     = 5,
    parameter int SERVE_FRAMES  = 60,
    parameter int WINNER_FRAMES = 300,
    parameter int FRM_W         = 10
) (
    input  logic         pclk,
    input  logic         rst,
    match_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SERVE_WAIT, S_WINNER} state_e;

    localparam logic [3:0]       WIN_N   = 4'(WIN_SCORE);
    localparam logic [FRM_W-1:0] SERVE_N = FRM_W'(SERVE_FRAMES);
    localparam logic [FRM_W-1:0] HOLD_N  = FRM_W'(WINNER_FRAMES);

    state_e           state_q, state_d;
    logic [3:0]       score1_q, score1_d, score2_q, score2_d;
    logic [FRM_W-1:0] frm_q, frm_d, frm_inc;
    logic             serve_q, serve_d;
    logic             won_q, won_d;
    logic             active_q, show_q;
    logic             vblnk_q, start_q;
    logic             frame_tick, start_rise;

    assign frame_tick = bus.vblnk_in & ~vblnk_q;
    assign start_rise = bus.start_btn & ~start_q;
    assign frm_inc    = frm_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        frm_d    = frm_q;
        serve_d  = 1'b0;
        won_d    = won_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    score1_d = '0;
                    score2_d = '0;
                    serve_d  = 1'b1;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                // simultaneous points are treated as a glitch and dropped
                if (bus.point_p1 && !bus.point_p2) begin
                    if (score1_q != WIN_N) score1_d = score1_q + 4'd1;
                    frm_d   = '0;
                    won_d   = (score1_q + 4'd1 == WIN_N) ? 1'b0 : won_q;
                    state_d = (score1_q + 4'd1 == WIN_N) ? S_WINNER : S_SERVE_WAIT;
                end else if (bus.point_p2 && !bus.point_p1) begin
                    if (score2_q != WIN_N) score2_d = score2_q + 4'd1;
                    frm_d   = '0;
                    won_d   = (score2_q + 4'd1 == WIN_N) ? 1'b1 : won_q;
                    state_d = (score2_q + 4'd1 == WIN_N) ? S_WINNER : S_SERVE_WAIT;
                end
            end
            S_SERVE_WAIT: begin
                if (frame_tick) begin
                    if (frm_inc == SERVE_N) begin
                        serve_d = 1'b1;
                        state_d = S_PLAY;
                    end else begin
                        frm_d = frm_inc;
                    end
                end
            end
            S_WINNER: begin
                if (start_rise) begin
                    score1_d = '0;
                    score2_d = '0;
                    serve_d  = 1'b1;
                    state_d  = S_PLAY;
                end else if (frame_tick) begin
                    if (frm_inc == HOLD_N) state_d = S_IDLE;
                    else                   frm_d   = frm_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            score1_q <= '0;
            score2_q <= '0;
            frm_q    <= '0;
            serve_q  <= 1'b0;
            won_q    <= 1'b0;
            active_q <= 1'b0;
            show_q   <= 1'b0;
            vblnk_q  <= 1'b0;
            // a button already held while in reset must not look like a fresh press
            start_q  <= bus.start_btn;
        end else begin
            state_q  <= state_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            frm_q    <= frm_d;
            serve_q  <= serve_d;
            won_q    <= won_d;
            active_q <= (state_d == S_PLAY);
            show_q   <= (state_d == S_WINNER);
            vblnk_q  <= bus.vblnk_in;
            start_q  <= bus.start_btn;
        end
    end

    assign bus.score_p1    = score1_q;
    assign bus.score_p2    = score2_q;
    assign bus.game_active = active_q;
    assign bus.serve       = serve_q;
    assign bus.show_winner = show_q;
    assign bus.player_won  = won_q;
endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed match scenarios, then random traffic
// compared every cycle against a behavioural match model.
module tb_match_ctrl;
    localparam int WIN_SCORE = 3, SERVE_FRAMES = 2, WINNER_FRAMES = 4;
    localparam int M_IDLE = 0, M_PLAY = 1, M_WAIT = 2, M_WIN = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    match_ctrl_if bus ();

    match_ctrl #(
        .WIN_SCORE(WIN_SCORE), .SERVE_FRAMES(SERVE_FRAMES),
        .WINNER_FRAMES(WINNER_FRAMES), .FRM_W(10)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    int errs = 0, checks = 0;
    int serve_cnt = 0;
    bit last_serve = 0;

    // behavioural model state
    int m_mode = M_IDLE, m_s1 = 0, m_s2 = 0, m_frames = 0;
    bit m_serve = 0, m_won = 0, m_vb = 0, m_st = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // a player scores; returns 1 if the match is over
    function automatic bit score_point(input bit p2);
        int s;
        if (p2) begin m_s2 = (m_s2 < WIN_SCORE) ? m_s2 + 1 : m_s2; s = m_s2; end
        else    begin m_s1 = (m_s1 < WIN_SCORE) ? m_s1 + 1 : m_s1; s = m_s1; end
        m_frames = 0;
        if (s == WIN_SCORE) begin m_won = p2; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit tick, rise;
        tick = bus.vblnk_in && !m_vb;
        rise = bus.start_btn && !m_st;
        m_vb = bus.vblnk_in;
        m_st = bus.start_btn;
        m_serve = 0;
        if (rst) begin
            m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_frames = 0; m_won = 0; m_vb = 0;
            return;
        end
        if (m_mode == M_IDLE) begin
            if (rise) begin m_s1 = 0; m_s2 = 0; m_serve = 1; m_mode = M_PLAY; end
        end else if (m_mode == M_PLAY) begin
            if (bus.point_p1 != bus.point_p2)
                m_mode = score_point(bus.point_p2) ? M_WIN : M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (tick) begin
                m_frames++;
                if (m_frames >= SERVE_FRAMES) begin m_serve = 1; m_mode = M_PLAY; end
            end
        end else begin
            if (rise) begin m_s1 = 0; m_s2 = 0; m_serve = 1; m_mode = M_PLAY; end
            else if (tick) begin
                m_frames++;
                if (m_frames >= WINNER_FRAMES) m_mode = M_IDLE;
            end
        end
    endtask

    task automatic step();
        @(posedge pclk);
        model_edge();
        #1;
        chk("score_p1", bus.score_p1, m_s1);
        chk("score_p2", bus.score_p2, m_s2);
        chk("game_active", bus.game_active, int'(m_mode == M_PLAY));
        chk("serve", bus.serve, m_serve);
        chk("show_winner", bus.show_winner, int'(m_mode == M_WIN));
        chk("player_won", bus.player_won, m_won);
        chk("serve_consec", int'(bus.serve && last_serve), 0);
        last_serve = bus.serve;
        if (bus.serve) serve_cnt++;
    endtask

    task automatic frame();
        bus.vblnk_in = 1; step();
        bus.vblnk_in = 0; step();
    endtask

    task automatic pulse(input bit p1, input bit p2);
        bus.point_p1 = p1; bus.point_p2 = p2; step();
        bus.point_p1 = 0;  bus.point_p2 = 0;
    endtask

    task automatic press();
        bus.start_btn = 1; step();
        bus.start_btn = 0; step();
    endtask

    initial begin
        int sc;
        bus.vblnk_in = 0; bus.point_p1 = 0; bus.point_p2 = 0; bus.start_btn = 0;
        // 1: reset, points ignored in IDLE
        repeat (3) step();
        rst = 0; step();
        chk("rst_score_p1", bus.score_p1, 0);
        chk("rst_active", bus.game_active, 0);
        chk("rst_show", bus.show_winner, 0);
        pulse(1, 0); step();
        chk("idle_point", bus.score_p1, 0);

        // 2: start, first point, serve after two frames
        bus.start_btn = 1; step();
        chk("start_serve", bus.serve, 1);
        chk("start_active", bus.game_active, 1);
        bus.start_btn = 0; step();
        chk("serve_one_cycle", bus.serve, 0);
        pulse(1, 0);
        chk("p1_score", bus.score_p1, 1);
        chk("p1_active_drop", bus.game_active, 0);
        sc = serve_cnt;
        frame();
        chk("wait_one_frame", bus.game_active, 0);
        frame();
        chk("reserve_pulses", serve_cnt - sc, 1);
        chk("reserve_active", bus.game_active, 1);

        // 3: p2 wins, winner screen then auto-return to IDLE
        pulse(0, 1); frame(); frame();
        pulse(0, 1); frame(); frame();
        pulse(0, 1);
        chk("p2_win_score", bus.score_p2, 3);
        chk("p2_win_show", bus.show_winner, 1);
        chk("p2_win_who", bus.player_won, 1);
        frame(); frame(); frame();
        chk("win_hold", bus.show_winner, 1);
        frame();
        chk("win_timeout", bus.show_winner, 0);
        chk("idle_keeps_p2", bus.score_p2, 3);
        chk("idle_inactive", bus.game_active, 0);

        // 4: simultaneous points dropped
        press();
        pulse(1, 1); step();
        chk("glitch_p1", bus.score_p1, 0);
        chk("glitch_p2", bus.score_p2, 0);
        chk("glitch_active", bus.game_active, 1);

        // 5: p1 wins, rematch on the second winner tick
        pulse(1, 0); frame(); frame();
        pulse(1, 0); frame(); frame();
        pulse(1, 0);
        chk("p1_win_who", bus.player_won, 0);
        frame();
        bus.vblnk_in = 1; bus.start_btn = 1; step();
        chk("rematch_serve", bus.serve, 1);
        chk("rematch_p1", bus.score_p1, 0);
        chk("rematch_active", bus.game_active, 1);
        bus.vblnk_in = 0; bus.start_btn = 0; step();

        // 6: reset in SERVE_WAIT at 2:1
        pulse(1, 0); frame(); frame();
        pulse(0, 1); frame(); frame();
        pulse(1, 0);
        chk("pre_rst_p1", bus.score_p1, 2);
        rst = 1; step(); rst = 0;
        chk("mid_rst_p1", bus.score_p1, 0);
        chk("mid_rst_serve", bus.serve, 0);
        sc = serve_cnt;
        frame(); frame();
        chk("no_serve_after_rst", serve_cnt - sc, 0);

        // start held through reset is not a press
        bus.start_btn = 1; rst = 1; step(); rst = 0; step(); step();
        chk("held_start", bus.game_active, 0);
        bus.start_btn = 0; step();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.vblnk_in  = ($urandom_range(0, 2) == 0);
            bus.point_p1  = ($urandom_range(0, 5) == 0);
            bus.point_p2  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 30) == 0) bus.start_btn = ~bus.start_btn;
            rst = ($urandom_range(0, 600) == 0);
            step();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
